// File: rtl/qmult_sched.sv
// Round-robin scheduler sharing one fixed-point qmult among NREQ requesters.
// Latency: accept at T, MUL at T+1, result valid from T+2; result port stalls the FSM in RESP.

module qmult #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic [N-1:0] o_result,
    output logic         ovr
);
    // Sign-magnitude: MSB is the sign, the remaining bits are the Q-format magnitude.
    logic [2*N-3:0] mag;

    assign mag      = {{(N-1){1'b0}}, i_multiplicand[N-2:0]} * {{(N-1){1'b0}}, i_multiplier[N-2:0]};
    assign o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], mag[N-2+Q:Q]};
    assign ovr      = |mag[2*N-3:N-1+Q];
endmodule

module qmult_sched #(
    parameter int Q    = 8,
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req_valid,
    output logic [NREQ-1:0]     o_req_ready,
    input  logic [NREQ*N-1:0]   i_multiplicand,
    input  logic [NREQ*N-1:0]   i_multiplier,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [IDW-1:0]      o_res_id,
    output logic [N-1:0]        o_result,
    output logic                o_ovr,
    output logic [NREQ-1:0]     o_ovr_sticky,
    input  logic [NREQ-1:0]     i_ovr_clr,
    output logic                o_busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_r;
    logic [N-1:0]    op_a, op_b;
    logic [N-1:0]    res_r;
    logic            ovr_r;
    logic [NREQ-1:0] sticky_r;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand;
    logic [IDW:0]    ptr_inc;
    logic [IDW-1:0]  rr_ptr_nxt;
    logic            accept;
    logic [N-1:0]    mul_res;
    logic            mul_ovr;
    logic [NREQ-1:0] sticky_set;

    // Scan from rr_ptr upward with wrap at NREQ, so non-power-of-two counts never yield an out-of-range index.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_vld && i_req_valid[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, grant_idx} + (IDW+1)'(1);
        if (ptr_inc >= (IDW+1)'(NREQ)) begin
            ptr_inc = '0;
        end
        rr_ptr_nxt = ptr_inc[IDW-1:0];
    end

    assign accept      = (state == IDLE) && grant_vld;
    assign o_req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MUL;
            MUL:  state_nxt = RESP;
            RESP: if (i_res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    qmult #(.Q(Q), .N(N)) u_qmult (
        .i_multiplicand (op_a),
        .i_multiplier   (op_b),
        .o_result       (mul_res),
        .ovr            (mul_ovr)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr <= '0;
            id_r   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            res_r  <= '0;
            ovr_r  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= rr_ptr_nxt;
                id_r   <= grant_idx;
                op_a   <= i_multiplicand[int'(grant_idx)*N +: N];
                op_b   <= i_multiplier[int'(grant_idx)*N +: N];
            end
            if (state == MUL) begin
                res_r <= mul_res;
                ovr_r <= mul_ovr;
            end
        end
    end

    // A set from the finishing multiply overrides a same-cycle clear of that bit.
    assign sticky_set = ((state == MUL) && mul_ovr) ? (NREQ'(1) << id_r) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sticky_r <= '0;
        end else begin
            sticky_r <= (sticky_r & ~i_ovr_clr) | sticky_set;
        end
    end

    assign o_res_valid  = (state == RESP);
    assign o_res_id     = id_r;
    assign o_result     = res_r;
    assign o_ovr        = ovr_r;
    assign o_ovr_sticky = sticky_r;
    assign o_busy       = (state != IDLE);
endmodule
